// File: rtl/led_scan_arbiter.sv
// -----------------------------------------------------------------------------
// led_scan_arbiter
//
// Scans an 8x8 LED frame buffer (4 bits per pixel: [3] stored, [2] G, [1] R)
// onto the matrix row/column pads. It also arbitrates the single frame-buffer
// RAM address/write port between the scanner, a writer port and a
// whole-buffer clear.
//
// Ports
//   clk, rst          : system clock, synchronous active-high reset
//   wr_req/row/col/data, wr_ack : writer handshake (ack = write issued now)
//   clr_req, clr_busy : level clear request, high while clearing
//   ram_addr_row/col, ram_data, ram_we : frame-buffer RAM port
//   ram_rd_data       : RAM read data, one cycle after the address
//   row_sel, col_r, col_g : registered matrix drive
//   frame_start       : pulse on the first FETCH cycle of row 0
// -----------------------------------------------------------------------------
module led_scan_arbiter #(
   parameter int unsigned ROW_HOLD = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_req,
   input  logic [2:0] wr_row,
   input  logic [2:0] wr_col,
   input  logic [3:0] wr_data,
   output logic       wr_ack,
   input  logic       clr_req,
   output logic       clr_busy,
   output logic [7:0] ram_addr_row,
   output logic [7:0] ram_addr_col,
   output logic [3:0] ram_data,
   output logic       ram_we,
   input  logic [3:0] ram_rd_data,
   output logic [7:0] row_sel,
   output logic [7:0] col_r,
   output logic [7:0] col_g,
   output logic       frame_start
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_SHOW  = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   localparam logic [15:0] HOLD_LAST = 16'(ROW_HOLD - 1);

   state_t      state_q, state_d;
   logic [2:0]  row_q, row_d;
   // Shared phase counter: fetch index k, SHOW hold count, or clear address.
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  shadow_q [8];
   logic [3:0]  shadow_d [8];
   logic [7:0]  row_sel_q, row_sel_d;
   logic [7:0]  col_r_q, col_r_d;
   logic [7:0]  col_g_q, col_g_d;
   logic [2:0]  cap_idx_s;

   // State register plus shadow row and registered matrix drive.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         row_q     <= 3'd0;
         cnt_q     <= 16'd0;
         row_sel_q <= 8'd0;
         col_r_q   <= 8'd0;
         col_g_q   <= 8'd0;
         for (int i = 0; i < 8; i++) begin
            shadow_q[i] <= 4'd0;
         end
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         cnt_q     <= cnt_d;
         row_sel_q <= row_sel_d;
         col_r_q   <= col_r_d;
         col_g_q   <= col_g_d;
         for (int i = 0; i < 8; i++) begin
            shadow_q[i] <= shadow_d[i];
         end
      end
   end

   // Read data lags the address by one cycle, so k lands in shadow[k-1].
   assign cap_idx_s = 3'(cnt_q[2:0] - 3'd1);

   // Next-state logic: phase sequencing, row advance and shadow capture.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < 8; i++) begin
         shadow_d[i] = shadow_q[i];
      end
      case (state_q)
         ST_FETCH: begin
            if (cnt_q != 16'd0) begin
               shadow_d[cap_idx_s] = ram_rd_data;
            end else begin
               shadow_d[0] = shadow_q[0];
            end
            if (cnt_q == 16'd8) begin
               state_d = ST_SHOW;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_SHOW: begin
            // Clear wins over both the writer and the row advance.
            if (clr_req) begin
               state_d = ST_CLEAR;
               cnt_d   = 16'd0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = ST_FETCH;
               row_d   = row_q + 3'd1;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == 16'd63) begin
               state_d = ST_FETCH;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_FETCH;
            cnt_d   = 16'd0;
         end
      endcase
   end

   // Output logic: RAM port mux, handshakes and next matrix drive.
   always_comb begin
      ram_addr_row = 8'd0;
      ram_addr_col = 8'd0;
      ram_data     = 4'd0;
      ram_we       = 1'b0;
      wr_ack       = 1'b0;
      clr_busy     = 1'b0;
      frame_start  = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (cnt_q < 16'd8) begin
               ram_addr_row = {5'd0, row_q};
               ram_addr_col = {5'd0, cnt_q[2:0]};
            end else begin
               ram_addr_row = 8'd0;
               ram_addr_col = 8'd0;
            end
            frame_start = (cnt_q == 16'd0) && (row_q == 3'd0);
         end
         ST_SHOW: begin
            if (wr_req && !clr_req) begin
               ram_addr_row = {5'd0, wr_row};
               ram_addr_col = {5'd0, wr_col};
               ram_data     = wr_data;
               ram_we       = 1'b1;
               wr_ack       = 1'b1;
            end else begin
               ram_we = 1'b0;
            end
         end
         ST_CLEAR: begin
            ram_addr_row = {5'd0, cnt_q[5:3]};
            ram_addr_col = {5'd0, cnt_q[2:0]};
            ram_we       = 1'b1;
            clr_busy     = 1'b1;
         end
         default: begin
            ram_we = 1'b0;
         end
      endcase

      // Matrix drive follows the next state so it only moves at boundaries.
      row_sel_d = 8'd0;
      col_r_d   = 8'd0;
      col_g_d   = 8'd0;
      if (state_d == ST_SHOW) begin
         row_sel_d = 8'd1 << row_d;
         for (int c = 0; c < 8; c++) begin
            col_r_d[c] = shadow_d[c][3] & shadow_d[c][1];
            col_g_d[c] = shadow_d[c][3] & shadow_d[c][2];
         end
      end else begin
         row_sel_d = 8'd0;
      end
   end

   assign row_sel = row_sel_q;
   assign col_r   = col_r_q;
   assign col_g   = col_g_q;

endmodule

// File: tb/tb_led_scan_arbiter.sv
module tb_led_scan_arbiter;

   localparam int H = 4;
   localparam int PH_FETCH = 0;
   localparam int PH_SHOW  = 1;
   localparam int PH_CLEAR = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_req = 1'b0;
   logic [2:0] wr_row = 3'd0;
   logic [2:0] wr_col = 3'd0;
   logic [3:0] wr_data = 4'd0;
   logic       wr_ack;
   logic       clr_req = 1'b0;
   logic       clr_busy;
   logic [7:0] ram_addr_row, ram_addr_col;
   logic [3:0] ram_data;
   logic       ram_we;
   logic [3:0] ram_rd_data;
   logic [7:0] row_sel, col_r, col_g;
   logic       frame_start;
   logic       preload = 1'b1;

   led_scan_arbiter #(.ROW_HOLD(H)) dut (
      .clk(clk), .rst(rst),
      .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
      .wr_ack(wr_ack), .clr_req(clr_req), .clr_busy(clr_busy),
      .ram_addr_row(ram_addr_row), .ram_addr_col(ram_addr_col),
      .ram_data(ram_data), .ram_we(ram_we), .ram_rd_data(ram_rd_data),
      .row_sel(row_sel), .col_r(col_r), .col_g(col_g), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // Frame-buffer RAM: synchronous read, write on ram_we.
   logic [3:0] mem [64];
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 64; i++) mem[i] <= 4'b1110;
      end else if (ram_we) begin
         mem[{ram_addr_row[2:0], ram_addr_col[2:0]}] <= ram_data;
      end
      ram_rd_data <= mem[{ram_addr_row[2:0], ram_addr_col[2:0]}];
   end

   // Reference model: phase, position in phase, row, latched row image.
   int         m_phase, m_t, m_row;
   logic [3:0] m_shadow [8];
   logic [3:0] ref_mem [64];

   logic [7:0] e_rs, e_cr, e_cg, e_ar, e_ac;
   logic [3:0] e_data;
   logic       e_we, e_ack, e_busy, e_fs;

   logic [7:0] s_rs, s_cr, s_cg, s_ar, s_ac;
   logic       s_we, s_ack, s_busy, s_fs;
   int         s_phase;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct {
      int         cyc;
      logic       wr;
      logic       clr;
      logic [7:0] rs;
      logic [7:0] cr;
      logic [7:0] cg;
      logic       fs;
   } vec_t;
   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_phase = PH_FETCH;
      m_t = 0;
      m_row = 0;
      for (int i = 0; i < 8; i++) m_shadow[i] = 4'd0;
   endtask

   task automatic model_expect();
      e_rs = 8'd0; e_cr = 8'd0; e_cg = 8'd0; e_ar = 8'd0; e_ac = 8'd0;
      e_data = 4'd0; e_we = 1'b0; e_ack = 1'b0; e_busy = 1'b0; e_fs = 1'b0;
      case (m_phase)
         PH_FETCH: begin
            if (m_t < 8) begin
               e_ar = 8'(m_row);
               e_ac = 8'(m_t);
            end
            e_fs = (m_t == 0) && (m_row == 0);
         end
         PH_SHOW: begin
            e_rs = 8'(1 << m_row);
            for (int c = 0; c < 8; c++) begin
               e_cr[c] = m_shadow[c][3] & m_shadow[c][1];
               e_cg[c] = m_shadow[c][3] & m_shadow[c][2];
            end
            if (wr_req && !clr_req) begin
               e_ar = {5'd0, wr_row};
               e_ac = {5'd0, wr_col};
               e_data = wr_data;
               e_we = 1'b1;
               e_ack = 1'b1;
            end
         end
         default: begin
            e_ar = 8'(m_t / 8);
            e_ac = 8'(m_t % 8);
            e_we = 1'b1;
            e_busy = 1'b1;
         end
      endcase
   endtask

   task automatic model_advance();
      if (e_we) ref_mem[{e_ar[2:0], e_ac[2:0]}] = e_data;
      if (rst) begin
         model_reset();
         return;
      end
      case (m_phase)
         PH_FETCH: begin
            m_t++;
            if (m_t == 9) begin
               m_phase = PH_SHOW;
               m_t = 0;
               for (int c = 0; c < 8; c++) m_shadow[c] = ref_mem[m_row * 8 + c];
            end
         end
         PH_SHOW: begin
            if (clr_req) begin
               m_phase = PH_CLEAR;
               m_t = 0;
            end else if (m_t == H - 1) begin
               m_row = (m_row + 1) % 8;
               m_phase = PH_FETCH;
               m_t = 0;
            end else begin
               m_t++;
            end
         end
         default: begin
            m_t++;
            if (m_t == 64) begin
               m_phase = PH_FETCH;
               m_t = 0;
            end
         end
      endcase
   endtask

   // One clock: sample and compare at negedge, advance model at posedge.
   task automatic step();
      @(negedge clk);
      model_expect();
      s_rs = row_sel; s_cr = col_r; s_cg = col_g; s_ar = ram_addr_row;
      s_ac = ram_addr_col; s_we = ram_we; s_ack = wr_ack; s_busy = clr_busy;
      s_fs = frame_start; s_phase = m_phase;
      chk("row_sel", 32'(row_sel), 32'(e_rs));
      chk("col_r", 32'(col_r), 32'(e_cr));
      chk("col_g", 32'(col_g), 32'(e_cg));
      chk("ram_addr_row", 32'(ram_addr_row), 32'(e_ar));
      chk("ram_addr_col", 32'(ram_addr_col), 32'(e_ac));
      chk("ram_data", 32'(ram_data), 32'(e_data));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("wr_ack", 32'(wr_ack), 32'(e_ack));
      chk("clr_busy", 32'(clr_busy), 32'(e_busy));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      @(posedge clk);
      model_advance();
      #1;
      cyc++;
   endtask

   task automatic run_until(input int ph, input int row, input int t);
      int budget;
      budget = 2000;
      while (!(m_phase == ph && (row < 0 || m_row == row) && m_t == t) && budget > 0) begin
         step();
         budget--;
      end
      if (budget == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL run_until: phase %0d row %0d t %0d not reached", ph, row, t);
      end
   endtask

   function automatic vec_t mk(int c, logic [7:0] rs, logic [7:0] cr, logic [7:0] cg, logic fs);
      vec_t v;
      v.cyc = c; v.wr = 1'b0; v.clr = 1'b0; v.rs = rs; v.cr = cr; v.cg = cg; v.fs = fs;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int cnt2;
      tbl[0] = mk(0,   8'h00, 8'h00, 8'h00, 1'b1);
      tbl[1] = mk(8,   8'h00, 8'h00, 8'h00, 1'b0);
      tbl[2] = mk(9,   8'h01, 8'hFF, 8'hFF, 1'b0);
      tbl[3] = mk(12,  8'h01, 8'hFF, 8'hFF, 1'b0);
      tbl[4] = mk(13,  8'h00, 8'h00, 8'h00, 1'b0);
      tbl[5] = mk(22,  8'h02, 8'hFF, 8'hFF, 1'b0);
      tbl[6] = mk(100, 8'h80, 8'hFF, 8'hFF, 1'b0);
      tbl[7] = mk(103, 8'h80, 8'hFF, 8'hFF, 1'b0);
      tbl[8] = mk(104, 8'h00, 8'h00, 8'h00, 1'b1);
      for (int i = 0; i < 64; i++) ref_mem[i] = 4'b1110;

      // Reset release with the buffer preloaded to 4'b1110.
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      preload = 1'b0;
      rst = 1'b0;
      model_reset();
      cyc = 0;

      for (int i = 0; i < 9; i++) begin
         wr_req = tbl[i].wr;
         clr_req = tbl[i].clr;
         while (cyc < tbl[i].cyc) step();
         step();
         chk("tbl_row_sel", 32'(s_rs), 32'(tbl[i].rs));
         chk("tbl_col_r", 32'(s_cr), 32'(tbl[i].cr));
         chk("tbl_col_g", 32'(s_cg), 32'(tbl[i].cg));
         chk("tbl_frame_start", 32'(s_fs), 32'(tbl[i].fs));
      end

      // One-cycle clear request: 64 busy cycles, then a dark row.
      run_until(PH_SHOW, -1, 0);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      cnt = 0;
      for (int i = 0; i < 70; i++) begin
         step();
         if (s_busy) cnt++;
      end
      chk("clear_busy_len", 32'(cnt), 32'd64);
      run_until(PH_SHOW, -1, 0);
      step();
      chk("clear_col_r", 32'(s_cr), 32'h00);
      chk("clear_col_g", 32'(s_cg), 32'h00);

      // Write raised mid-FETCH is granted in the first SHOW cycle.
      run_until(PH_FETCH, 3, 2);
      wr_req = 1'b1; wr_row = 3'd3; wr_col = 3'd5; wr_data = 4'b1010;
      repeat (7) step();
      step();
      chk("wr_first_show_ack", 32'(s_ack), 32'd1);
      chk("wr_first_show_we", 32'(s_we), 32'd1);
      chk("wr_addr", 32'({s_ar, s_ac}), 32'h0305);
      wr_req = 1'b0;
      run_until(PH_SHOW, 3, 0);
      step();
      chk("wr_visible_col_r", 32'(s_cr), 32'h20);
      chk("wr_visible_col_g", 32'(s_cg), 32'h00);

      // Simultaneous write and clear: clear wins, write waits.
      run_until(PH_SHOW, -1, 1);
      wr_req = 1'b1; wr_row = 3'd6; wr_col = 3'd2; wr_data = 4'b1100;
      clr_req = 1'b1;
      step();
      chk("same_cycle_ack", 32'(s_ack), 32'd0);
      clr_req = 1'b0;
      cnt = 0;
      for (int i = 0; i < 73; i++) begin
         step();
         if (s_ack) cnt++;
      end
      chk("no_ack_during_clear", 32'(cnt), 32'd0);
      step();
      chk("ack_after_clear", 32'(s_ack), 32'd1);
      wr_req = 1'b0;
      run_until(PH_SHOW, 6, 0);
      step();
      chk("only_pixel_col_g", 32'(s_cg), 32'h04);
      chk("only_pixel_col_r", 32'(s_cr), 32'h00);

      // Reset in the middle of a clear.
      run_until(PH_SHOW, -1, 0);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      run_until(PH_CLEAR, -1, 20);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("rst_frame_start", 32'(s_fs), 32'd1);
      chk("rst_clr_busy", 32'(s_busy), 32'd0);
      chk("rst_row_sel", 32'(s_rs), 32'd0);
      chk("rst_ram_we", 32'(s_we), 32'd0);

      // Held request across a whole row: one ack per SHOW cycle.
      run_until(PH_FETCH, -1, 0);
      wr_req = 1'b1; wr_row = 3'd1; wr_col = 3'd1; wr_data = 4'b1000;
      cnt = 0;
      cnt2 = 0;
      for (int i = 0; i < 13; i++) begin
         step();
         if (s_ack) begin
            cnt++;
            wr_row = 3'($urandom); wr_col = 3'($urandom); wr_data = 4'($urandom);
         end
         if (s_we && s_phase == PH_FETCH) cnt2++;
      end
      chk("held_ack_count", 32'(cnt), 32'd4);
      chk("we_in_fetch", 32'(cnt2), 32'd0);
      wr_req = 1'b0;

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if (!wr_req || s_ack) begin
            wr_req = ($urandom_range(0, 2) == 0);
            wr_row = 3'($urandom);
            wr_col = 3'($urandom);
            wr_data = 4'($urandom);
         end
         clr_req = ($urandom_range(0, 60) == 0);
         step();
      end
      wr_req = 1'b0;
      clr_req = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
